// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, start-bit validation at mid-bit,
// LSB-first centre sampling, stop-bit check with break hold-off.
module uart_rx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state_q;
  logic        sync1_q;
  logic        sync2_q;
  logic [15:0] clk_count_q;
  logic [2:0]  bit_index_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        rx_busy_q;
  logic        frame_err_q;

  logic rx_s;
  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      clk_count_q <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      // rx_busy_q is updated alongside every state transition so it tracks state_q exactly
      unique case (state_q)
        IDLE: begin
          rx_busy_q <= 1'b0;
          if (!rx_s) begin
            clk_count_q <= '0;
            state_q     <= START;
            rx_busy_q   <= 1'b1;
          end
        end

        START: begin
          if (clk_count_q == HALF_LAST) begin
            if (!rx_s) begin
              clk_count_q <= '0;
              bit_index_q <= '0;
              state_q     <= DATA;
            end else begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end
          end else begin
            clk_count_q <= clk_count_q + 16'd1;
          end
        end

        DATA: begin
          if (clk_count_q == BIT_LAST) begin
            clk_count_q          <= '0;
            shift_q[bit_index_q] <= rx_s;
            if (bit_index_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_index_q <= bit_index_q + 3'd1;
            end
          end else begin
            clk_count_q <= clk_count_q + 16'd1;
          end
        end

        STOP: begin
          if (clk_count_q == BIT_LAST) begin
            clk_count_q <= '0;
            if (rx_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= IDLE;
              rx_busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            clk_count_q <= clk_count_q + 16'd1;
          end
        end

        BREAK: begin
          // A held-low line must return high before another start bit is honoured
          if (rx_s) begin
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit (CLK_FREQ=160, BAUD_RATE=10).
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int         v_cyc[$];
  logic [7:0] v_data[$];
  int         e_cyc[$];
  int         r_cyc[$];
  int         f_cyc[$];
  int         both_cnt = 0;
  logic       busy_prev = 1'b0;

  uart_rx #(
    .CLK_FREQ (160),
    .BAUD_RATE(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: pulses and busy edges, sampled mid-cycle
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_data.push_back(rx_data);
    end
    if (frame_err === 1'b1) e_cyc.push_back(cyc);
    if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    if (busy_prev !== 1'b1 && rx_busy === 1'b1) r_cyc.push_back(cyc);
    if (busy_prev === 1'b1 && rx_busy !== 1'b1) f_cyc.push_back(cyc);
    busy_prev = rx_busy;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_good_byte();
    int vb, eb, rb, fb, c0;
    vb = v_cyc.size(); eb = e_cyc.size(); rb = r_cyc.size(); fb = f_cyc.size();
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(8);
    n_cmp++; if (v_cyc.size() - vb != 1) begin n_err++; $display("FAIL good_valid_count: got %0d want 1", v_cyc.size() - vb); end
    if (v_cyc.size() > vb) begin
      n_cmp++; if (v_data[vb] !== 8'hA5) begin n_err++; $display("FAIL good_data: got %h want a5", v_data[vb]); end
      // rx falls at c0; two sync stages then HALF_BIT + 9*CPB = 152 clocks to the valid edge
      n_cmp++; if (v_cyc[vb] - c0 < 154 || v_cyc[vb] - c0 > 156) begin n_err++; $display("FAIL good_latency: got %0d want 155+-1", v_cyc[vb] - c0); end
      if (f_cyc.size() > fb) begin
        n_cmp++; if (f_cyc[fb] != v_cyc[vb]) begin n_err++; $display("FAIL good_busy_fall: got cyc %0d want %0d", f_cyc[fb], v_cyc[vb]); end
      end
    end
    n_cmp++; if (r_cyc.size() - rb != 1 || f_cyc.size() - fb != 1) begin n_err++; $display("FAIL good_busy_edges: got rise %0d fall %0d want 1 1", r_cyc.size() - rb, f_cyc.size() - fb); end
    n_cmp++; if (e_cyc.size() != eb) begin n_err++; $display("FAIL good_ferr: got %0d pulses want 0", e_cyc.size() - eb); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL good_data_hold: got %h want a5", rx_data); end
  endtask

  task automatic test_glitch();
    int vb, eb, rb, fb;
    vb = v_cyc.size(); eb = e_cyc.size(); rb = r_cyc.size(); fb = f_cyc.size();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    n_cmp++; if (r_cyc.size() - rb != 1 || f_cyc.size() - fb != 1) begin n_err++; $display("FAIL glitch_busy_edges: got rise %0d fall %0d want 1 1", r_cyc.size() - rb, f_cyc.size() - fb); end
    if (r_cyc.size() > rb && f_cyc.size() > fb) begin
      n_cmp++; if (f_cyc[fb] - r_cyc[rb] > 8 || f_cyc[fb] <= r_cyc[rb]) begin n_err++; $display("FAIL glitch_busy_width: got %0d want 1..8", f_cyc[fb] - r_cyc[rb]); end
    end
    n_cmp++; if (v_cyc.size() != vb || e_cyc.size() != eb) begin n_err++; $display("FAIL glitch_pulses: got valid %0d ferr %0d want 0 0", v_cyc.size() - vb, e_cyc.size() - eb); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL glitch_data: got %h want a5", rx_data); end
  endtask

  task automatic test_break();
    int vb, eb, fb, line_high;
    vb = v_cyc.size(); eb = e_cyc.size(); fb = f_cyc.size();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (e_cyc.size() - eb != 1) begin n_err++; $display("FAIL break_ferr_count: got %0d want 1", e_cyc.size() - eb); end
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL break_busy_held: got %b want 1", rx_busy); end
    line_high = cyc;
    idle(10);
    n_cmp++; if (f_cyc.size() - fb != 1) begin n_err++; $display("FAIL break_busy_fall_count: got %0d want 1", f_cyc.size() - fb); end
    if (f_cyc.size() > fb) begin
      n_cmp++; if (f_cyc[fb] <= line_high) begin n_err++; $display("FAIL break_busy_fall_time: got cyc %0d want > %0d", f_cyc[fb], line_high); end
    end
    idle(200);
    n_cmp++; if (v_cyc.size() != vb) begin n_err++; $display("FAIL break_spurious_valid: got %0d want 0", v_cyc.size() - vb); end
    n_cmp++; if (e_cyc.size() - eb != 1) begin n_err++; $display("FAIL break_spurious_ferr: got %0d want 1", e_cyc.size() - eb); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL break_data: got %h want a5", rx_data); end
  endtask

  task automatic test_back_to_back();
    int vb, eb;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h81;
    vb = v_cyc.size(); eb = e_cyc.size();
    for (int k = 0; k < 3; k++) send_frame(exp_b[k], 1'b1);
    idle(10);
    n_cmp++; if (v_cyc.size() - vb != 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", v_cyc.size() - vb); end
    if (v_cyc.size() - vb >= 3) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (v_data[vb + k] !== exp_b[k]) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", k, v_data[vb + k], exp_b[k]); end
      end
      for (int k = 1; k < 3; k++) begin
        n_cmp++; if (v_cyc[vb + k] - v_cyc[vb + k - 1] < 159 || v_cyc[vb + k] - v_cyc[vb + k - 1] > 161) begin
          n_err++; $display("FAIL b2b_spacing%0d: got %0d want 160+-1", k, v_cyc[vb + k] - v_cyc[vb + k - 1]);
        end
      end
    end
    n_cmp++; if (e_cyc.size() != eb || both_cnt != 0) begin n_err++; $display("FAIL b2b_ferr: got ferr %0d overlap %0d want 0 0", e_cyc.size() - eb, both_cnt); end
  endtask

  task automatic test_reset_abort();
    int vb, eb;
    logic [7:0] b;
    b = 8'h55;
    vb = v_cyc.size(); eb = e_cyc.size();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", rx_busy); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL abort_data: got %h want 00", rx_data); end
    rst = 1'b0;
    idle(10);
    n_cmp++; if (v_cyc.size() != vb) begin n_err++; $display("FAIL abort_no_pulse: got %0d want 0", v_cyc.size() - vb); end
    send_frame(8'h12, 1'b1);
    idle(10);
    n_cmp++; if (v_cyc.size() - vb != 1) begin n_err++; $display("FAIL abort_resume_count: got %0d want 1", v_cyc.size() - vb); end
    if (v_cyc.size() > vb) begin
      n_cmp++; if (v_data[vb] !== 8'h12) begin n_err++; $display("FAIL abort_resume_data: got %h want 12", v_data[vb]); end
    end
    n_cmp++; if (e_cyc.size() != eb) begin n_err++; $display("FAIL abort_ferr: got %0d want 0", e_cyc.size() - eb); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_byte();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
